// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  // Requester index (0 or 1).
  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/ram_arbiter_2p_rr_arb2.sv
// Two-way round-robin grant. This block is purely combinational; the pointer lives in the parent.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_id_t            ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output req_id_t            gnt_idx_o
);

  // A lone requester always wins. On a tie, the requester named by ptr_i wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    unique case (valid_i)
      2'b01: begin
        gnt_o     = 2'b01;
        gnt_idx_o = 1'b0;
      end
      2'b10: begin
        gnt_o     = 2'b10;
        gnt_idx_o = 1'b1;
      end
      2'b11: begin
        gnt_o     = ptr_i ? 2'b10 : 2'b01;
        gnt_idx_o = ptr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port synchronous RAM between two requesters.
// After reset it zero-fills the RAM, then grants requests round-robin.
// Each read response goes back to the requester that issued the read.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_we,
  input  logic [2*ADDR_WIDTH-1:0]       req_addr,
  input  logic [2*DATA_WIDTH-1:0]       req_wdata,
  output logic [1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          init_done,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  arb_state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]         init_cnt_q, init_cnt_d;
  req_id_t                       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
  logic                          init_done_q, init_done_d;
  logic [ADDR_WIDTH-1:0]         last_addr_q, last_addr_d;

  // Per-requester views of the packed request buses.
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  // Requests are invisible to the arbiter until the init sweep is done.
  logic [NUM_REQ-1:0] arb_valid;
  logic [NUM_REQ-1:0] gnt;
  req_id_t            gnt_idx;
  assign arb_valid = (state_q == RUN) ? req_valid : '0;

  rr_arb2 u_rr_arb2 (
    .valid_i   (arb_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Read data returns straight from the RAM. rsp_valid marks which requester owns it.
  assign rsp_rdata = ram_dout;
  assign rsp_valid = rsp_valid_q;
  assign init_done = init_done_q;

  // Next-state logic and RAM-side outputs for the init sweep and run phases.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = '0;
    init_done_d = init_done_q;
    last_addr_d = last_addr_q;
    req_ready   = '0;
    ram_we      = 1'b0;
    ram_addr    = last_addr_q;
    ram_din     = '0;
    unique case (state_q)
      INIT: begin
        ram_we   = 1'b1;
        ram_addr = init_cnt_q;
        if (init_cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      RUN: begin
        req_ready = gnt;
        if (|gnt) begin
          ram_we      = req_we[gnt_idx];
          ram_addr    = addr_v[gnt_idx];
          ram_din     = wdata_v[gnt_idx];
          last_addr_d = addr_v[gnt_idx];
          rr_ptr_d    = ~gnt_idx;
          // Reads get a response on the next cycle. Writes get none.
          rsp_valid_d = gnt & ~req_we;
        end
      end
      default: ;
    endcase
  end

  // State registers. A reset drops any pending response and restarts the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
      init_done_q <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      init_done_q <= init_done_d;
      last_addr_q <= last_addr_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: a behavioural RAM, a high-level reference model, directed and random stimulus.
module tb_ram_arbiter_2p;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_ready;
  logic [1:0]      req_we = '0;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            init_done;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;

  ram_arbiter_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with a 1-cycle read.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: memory contents, the preferred requester on a tie, and the last granted address.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_pref;
  logic [AW-1:0] m_last_addr;

  task automatic set_req(input int i, input bit v, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Call this at a negedge with the inputs already set.
  // It checks the grant and the RAM port, advances one clock, then checks the response.
  task automatic cycle(output int g);
    logic [1:0]    exp_rdy;
    logic [1:0]    exp_rsp;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] a;
    #1;
    g = -1;
    if (req_valid == 2'b01) g = 0;
    else if (req_valid == 2'b10) g = 1;
    else if (req_valid == 2'b11) g = m_pref;
    exp_rdy = (g < 0) ? 2'b00 : (g == 0 ? 2'b01 : 2'b10);
    exp_rsp = 2'b00;
    exp_data = '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("init_done_run", init_done, 1);
    if (g < 0) begin
      chk("idle_ram_we", ram_we, 0);
      chk("idle_ram_addr", ram_addr, m_last_addr);
      chk("idle_ram_din", ram_din, 0);
    end else begin
      a = req_addr[g*AW +: AW];
      chk("ram_we", ram_we, req_we[g]);
      chk("ram_addr", ram_addr, a);
      chk("ram_din", ram_din, req_wdata[g*DW +: DW]);
      m_last_addr = a;
      m_pref = 1 - g;
      if (req_we[g]) m_mem[a] = req_wdata[g*DW +: DW];
      else begin
        exp_rsp[g] = 1'b1;
        exp_data = m_mem[a];
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp != 2'b00) chk("rsp_rdata", rsp_rdata, exp_data);
  endtask

  // Assert reset, check the reset outputs, release, then check the whole zero-fill sweep.
  // Both requesters stay valid throughout and must never be accepted.
  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1, 0, 4'd9, 8'h00);
    set_req(1, 1, 1, 4'd3, 8'h77);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ram_we", ram_we, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_init_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      chk("init_req_ready", req_ready, 0);
      chk("init_ram_we", ram_we, 1);
      chk("init_ram_addr", ram_addr, k);
      chk("init_ram_din", ram_din, 0);
      chk("init_done_low", init_done, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      @(posedge clk);
      @(negedge clk);
    end
    chk("init_done_high", init_done, 1);
    for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    m_pref = 0;
    m_last_addr = '0;
    req_valid = 2'b00;
  endtask

  initial begin
    int g;
    bit            pv  [2];
    bit            pwe [2];
    logic [AW-1:0] pa  [2];
    logic [DW-1:0] pd  [2];

    do_reset();

    // Every location reads back zero after the sweep.
    for (int a = 0; a < DEPTH; a++) begin
      set_req(0, 1, 0, AW'(a), 8'h00);
      cycle(g);
    end
    set_req(0, 0, 0, 0, 0);
    cycle(g);

    // Single requester: write, then read back. Then one idle cycle.
    set_req(0, 1, 1, 4'd5, 8'h2A); cycle(g);
    set_req(0, 1, 0, 4'd5, 8'h00); cycle(g);
    chk("single_rdata", rsp_rdata, 8'h2A);
    set_req(0, 0, 0, 0, 0); cycle(g);

    // Contention: both requesters write continuously. Then read both addresses back.
    for (int n = 0; n < 8; n++) begin
      set_req(0, 1, 1, 4'd1, DW'(8'h10 + n));
      set_req(1, 1, 1, 4'd2, DW'(8'h20 + n));
      cycle(g);
    end
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 0, 4'd1, 0); cycle(g);
    set_req(0, 1, 0, 4'd2, 0); cycle(g);
    set_req(0, 0, 0, 0, 0);

    // Interleaved reads: preload two addresses, then both requesters read at once.
    set_req(0, 1, 1, 4'd3, 8'h11); cycle(g);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 1, 1, 4'd4, 8'h22); cycle(g);
    set_req(0, 1, 0, 4'd3, 0);
    set_req(1, 1, 0, 4'd4, 0);
    cycle(g);
    set_req(g, 0, 0, 0, 0);
    cycle(g);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);

    // Write, then read the same address on the very next cycle.
    set_req(1, 1, 1, 4'd15, 8'hFF); cycle(g);
    set_req(1, 0, 0, 0, 0);
    set_req(0, 1, 0, 4'd15, 0); cycle(g);
    chk("wtr_rdata", rsp_rdata, 8'hFF);
    set_req(0, 0, 0, 0, 0);

    // Random traffic. A request is held until it is accepted.
    for (int i = 0; i < 2; i++) pv[i] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && ($urandom_range(0, 9) < 6)) begin
          pv[i]  = 1;
          pwe[i] = $urandom_range(0, 1);
          pa[i]  = AW'($urandom_range(0, DEPTH - 1));
          pd[i]  = DW'($urandom);
        end
        set_req(i, pv[i], pwe[i], pa[i], pd[i]);
      end
      cycle(g);
      if (g >= 0) pv[g] = 0;
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);

    // Reset while a read is outstanding: the response must be dropped and the RAM zeroed.
    set_req(0, 1, 1, 4'd7, 8'hA5); cycle(g);
    set_req(0, 1, 0, 4'd7, 0);
    #1;
    @(posedge clk);
    #1;
    chk("pre_reset_rsp_valid", rsp_valid, 2'b01);
    do_reset();
    set_req(0, 1, 0, 4'd7, 0); cycle(g);
    chk("post_reset_rdata", rsp_rdata, 8'h00);
    set_req(0, 0, 0, 0, 0); cycle(g);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
Controller that shares one synchronous single-port RAM (1-cycle read latency, write on we at posedge) between two requesters. After reset it runs an init sweep that writes zero to every location. It then arbitrates requests round-robin with a valid/ready handshake and routes each read response back to the requester that issued it. It sits between the RAM instance and two client blocks, such as a fetch unit and a load/store unit.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH locations
DATA_WIDTH, 8, RAM data width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept; handshake when valid & ready at posedge
req_we  in  2  per-requester write enable (1 = write, 0 = read)
req_addr  in  2*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  2*DATA_WIDTH  packed write data, same packing
rsp_valid  out  2  one-cycle pulse; read data for requester i is valid
rsp_rdata  out  DATA_WIDTH  read data, shared bus, qualified by rsp_valid
init_done  out  1  high once the init sweep completes
ram_we  out  1  to RAM we
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_din  out  DATA_WIDTH  to RAM din
ram_dout  in  DATA_WIDTH  from RAM dout (valid 1 cycle after the read address is presented)

Behaviour:
- Reset (rst_n low, asynchronous)
  - state=INIT, init_cnt=0, rr_ptr=0, rsp_valid=0, init_done=0.
  - Combinational outputs while in reset: req_ready=0, ram_we=1, ram_addr=0, ram_din=0.
- State INIT
  - ram_we=1, ram_addr=init_cnt, ram_din=0, req_ready=2'b00.
  - init_cnt increments each cycle.
  - When init_cnt==DEPTH-1, the next state is RUN and init_done is registered high.
  - The sweep takes exactly DEPTH cycles after rst_n deasserts.
- State RUN (terminal until reset)
  - Grant (combinational):
    - If exactly one req_valid bit is set, that requester is granted.
    - If both are set, requester rr_ptr is granted.
    - If none is set, no grant.
  - req_ready = one-hot grant. The ready of a non-granted requester is 0, and req_ready never depends on its own ready.
  - On a grant g: ram_we=req_we[g], ram_addr=req_addr[g], ram_din=req_wdata[g].
  - With no grant: ram_we=0, ram_addr holds the last granted address (registered), ram_din=0.
  - rr_ptr update: after any grant to g, rr_ptr <= ~g. With no grant, rr_ptr holds.
  - Under continuous contention, grants strictly alternate.
- Read response
  - rsp_valid[g] <= grant & ~req_we[g], so the pulse appears exactly 1 cycle after the read handshake.
  - rsp_rdata = ram_dout combinationally (no extra register).
  - Total read latency: handshake edge + 1 cycle.
  - Back-to-back reads (any mix of requesters) give back-to-back responses in issue order.
- Writes
  - Complete at the handshake edge and produce no response.
  - A read to the same address in the next cycle returns the new data.
- Boundaries
  - Address DEPTH-1 is legal. The init counter stops, with no wrap, after DEPTH-1.
  - req_valid during INIT is ignored, not accepted, and not lost: the requester keeps valid asserted.
  - A reset mid-RUN drops any pending response (rsp_valid cleared immediately) and restarts INIT, which zeroes the RAM again.
  - A requester may change its request only after its handshake. The controller does not check this.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef enum logic {INIT, RUN} arb_state_t
  - localparam NUM_REQ=2
  - index typedef for requester id
- Sub-module rr_arb2: inputs valid[1:0], ptr. Outputs one-hot grant and grant index. Purely combinational. rr_ptr stays in the parent.
- The RAM is not instantiated inside the block. Benches connect single_port_ram to the ram_* ports.

Test Plan:
- Init sweep: deassert rst_n with req_valid=2'b11 held → req_ready=0 for 16 cycles, ram_we=1, ram_addr 0..15, ram_din=0, then init_done=1; reads of addr 0..15 return 0.
- Single requester: req0 writes 8'h2A to addr 5, then reads addr 5 → rsp_valid=2'b01 exactly 1 cycle after the read handshake, rsp_rdata=8'h2A, rsp_valid[1] stays 0.
- Contention: both valid continuously after init, req0 writing addr 1 and req1 writing addr 2 → grants 0,1,0,1…; each requester is accepted every other cycle; a final readback gives the written data.
- Interleaved reads: addr3=8'h11 and addr4=8'h22 preloaded; req0 reads addr 3 and req1 reads addr 4, both valid → rsp_valid=01 with 8'h11, then 10 with 8'h22, on consecutive cycles.
- Write-then-read, same address: req1 writes 8'hFF to addr 15 and req0 reads addr 15 in the next cycle → req0 receives 8'hFF.
- Reset mid-operation: rst_n pulsed low while a read to addr 7 is outstanding → rsp_valid drops to 0 immediately, no response is delivered, INIT reruns, and addr 7 reads back 0.
